pic_led_scan: RTL and testbench

// - Captures a window of parallel RGB video (vs/hs/de + 8b R/G/B) into an on-chip 1bpp frame buffer.
// - Scans the buffer out to four chained HUB75-style LED matrix panels: shared clk/latch/OE/row address, plus per-panel R0/G0/B0 (upper half) and R1/G1/B1 (lower half).
// - Sits between the video receiver front end and the LED connector; a single clock drives both capture and scan.

---
 rtl/pic_led_scan.sv | 265 ++++++++++++++++++++++++++
 tb/tb_pic_led_scan.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_led_scan.sv
// pic_led_scan: captures a window of parallel RGB video into a 1bpp frame
// buffer and scans it out to a chain of HUB75-style LED panels.
// Capture and scan share one clock; scanning free-runs regardless of input timing.
// Build option: define RB_SWAP_EN to exchange the red and blue inputs before
// storage (for boards with the BLUE/RED lines crossed).
module pic_led_scan #(
  parameter int PANEL_W   = 64,
  parameter int PANELS    = 4,
  parameter int ROWS      = 32,
  parameter int ON_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        vs,
  input  logic                        hs,
  input  logic                        de,
  input  logic [7:0]                  red,
  input  logic [7:0]                  green,
  input  logic [7:0]                  blue,
  output logic                        dvi_hpd,
  output logic                        led_clk,
  output logic                        led_lt,
  output logic                        led_oe,
  output logic [$clog2(ROWS/2)-1:0]   led_a,
  output logic [PANELS-1:0]           led_r0,
  output logic [PANELS-1:0]           led_g0,
  output logic [PANELS-1:0]           led_b0,
  output logic [PANELS-1:0]           led_r1,
  output logic [PANELS-1:0]           led_g1,
  output logic [PANELS-1:0]           led_b1
);

  localparam int HALF_ROWS = ROWS / 2;
  localparam int A_W       = $clog2(HALF_ROWS);
  localparam int COL_W     = $clog2(PANEL_W);
  localparam int P_W       = $clog2(PANELS);
  localparam int BANKS     = 2 * PANELS;
  localparam int B_W       = P_W + 1;
  localparam int DEPTH     = PANEL_W * HALF_ROWS;
  localparam int ADDR_W    = A_W + COL_W;
  localparam int X_W       = $clog2(PANELS * PANEL_W) + 1;
  localparam int Y_W       = $clog2(ROWS) + 1;
  localparam int SHIFT_CYC = 2 * PANEL_W;
  localparam int CNT_MAX   = (ON_CYCLES > SHIFT_CYC) ? ON_CYCLES : SHIFT_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX) + 1;

  localparam logic [X_W-1:0]   X_LIM      = X_W'(PANELS * PANEL_W);
  localparam logic [Y_W-1:0]   Y_LIM      = Y_W'(ROWS);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SHIFT   = 2'd0,
    ST_BLANK   = 2'd1,
    ST_LATCH   = 2'd2,
    ST_DISPLAY = 2'd3
  } state_t;

  // ---------------- capture side ----------------
  logic             vs_d_r, de_d_r;
  logic [X_W-1:0]   x_r;
  logic [Y_W-1:0]   y_r;
  logic             vs_rise_s, de_rise_s, de_fall_s;
  logic [X_W-1:0]   x_cur_s;
  logic [Y_W-1:0]   y_cur_s;
  logic             wr_en_s;
  logic [B_W-1:0]   wr_bank_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [2:0]       pix_s;
  logic             unused_s;

  // hs and the low colour bits carry no information for a 1bpp buffer
  assign unused_s = ^{hs, red[6:0], green[6:0], blue[6:0]};

  // Edge detection, effective write position and bank/address selection
  always_comb begin
    vs_rise_s = vs & ~vs_d_r;
    de_rise_s = de & ~de_d_r;
    de_fall_s = ~de & de_d_r;
    if (de_rise_s) begin
      x_cur_s = '0;
    end else begin
      x_cur_s = x_r;
    end
    if (vs_rise_s) begin
      y_cur_s = '0;
    end else begin
      y_cur_s = y_r;
    end
    wr_en_s   = de && (x_cur_s < X_LIM) && (y_cur_s < Y_LIM);
    wr_bank_s = {x_cur_s[COL_W +: P_W], y_cur_s[A_W]};
    wr_addr_s = {y_cur_s[A_W-1:0], x_cur_s[COL_W-1:0]};
`ifdef RB_SWAP_EN
    pix_s = {blue[7], green[7], red[7]};
`else
    pix_s = {red[7], green[7], blue[7]};
`endif
  end

  // Capture counters: x restarts on each line, y restarts on each frame
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d_r <= 1'b0;
      de_d_r <= 1'b0;
      x_r    <= '0;
      y_r    <= '0;
    end else begin
      vs_d_r <= vs;
      de_d_r <= de;
      if (de) begin
        if (x_cur_s < X_LIM) begin
          x_r <= x_cur_s + X_W'(1);
        end else begin
          x_r <= x_cur_s;
        end
      end
      if (vs_rise_s) begin
        y_r <= '0;
      end else if (de_fall_s && (y_r < Y_LIM)) begin
        y_r <= y_r + Y_W'(1);
      end
    end
  end

  // ---------------- frame buffer ----------------
  logic [2:0]        mem_r [0:BANKS-1][0:DEPTH-1];
  logic [2:0]        rd_r  [0:BANKS-1];
  logic [ADDR_W-1:0] rd_addr_s;

  // One write port, all banks read in parallel; a same-cycle read sees old data.
  // Deliberately not reset so the image survives a reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_bank_s][wr_addr_s] <= pix_s;
    end
    for (int b = 0; b < BANKS; b++) begin
      rd_r[b] <= mem_r[b][rd_addr_s];
    end
  end

  // ---------------- scan FSM ----------------
  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [A_W-1:0]   row_r, row_nxt_s;

  // State, phase counter and row pair registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_SHIFT;
      cnt_r   <= '0;
      row_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      row_r   <= row_nxt_s;
    end
  end

  // Next-state logic for SHIFT -> BLANK -> LATCH -> DISPLAY -> SHIFT
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + CNT_W'(1);
    row_nxt_s   = row_r;
    case (state_r)
      ST_SHIFT: begin
        if (cnt_r == SHIFT_LAST) begin
          state_nxt_s = ST_BLANK;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_BLANK: begin
        state_nxt_s = ST_LATCH;
        cnt_nxt_s   = '0;
      end
      ST_LATCH: begin
        state_nxt_s = ST_DISPLAY;
        cnt_nxt_s   = '0;
      end
      ST_DISPLAY: begin
        if (cnt_r == ON_LAST) begin
          state_nxt_s = ST_SHIFT;
          cnt_nxt_s   = '0;
          row_nxt_s   = row_r + A_W'(1);
        end else begin
          state_nxt_s = ST_DISPLAY;
        end
      end
      default: begin
        state_nxt_s = ST_SHIFT;
        cnt_nxt_s   = '0;
        row_nxt_s   = '0;
      end
    endcase
  end

  // Read one cycle ahead: the column the next SHIFT phase-0 cycle will present.
  // During reset, point at row 0 col 0 so the first column after release is valid.
  always_comb begin
    if (rst) begin
      rd_addr_s = '0;
    end else begin
      rd_addr_s = {row_nxt_s, cnt_nxt_s[COL_W:1]};
    end
  end

  // ---------------- registered panel outputs ----------------
  logic [PANELS-1:0] r0_s, g0_s, b0_s, r1_s, g1_s, b1_s;
  logic [PANELS-1:0] r0_r, g0_r, b0_r, r1_r, g1_r, b1_r;
  logic              led_clk_r, led_lt_r, led_oe_r, hpd_r;
  logic [A_W-1:0]    led_a_r;

  // Bank (panel p, half h) sits at index 2*p+h; route its bits to the panel pins
  always_comb begin
    r0_s = '0; g0_s = '0; b0_s = '0;
    r1_s = '0; g1_s = '0; b1_s = '0;
    for (int p = 0; p < PANELS; p++) begin
      r0_s[p] = rd_r[2*p][2];
      g0_s[p] = rd_r[2*p][1];
      b0_s[p] = rd_r[2*p][0];
      r1_s[p] = rd_r[2*p+1][2];
      g1_s[p] = rd_r[2*p+1][1];
      b1_s[p] = rd_r[2*p+1][0];
    end
  end

  // Panel control and colour registers, driven from the current FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      led_clk_r <= 1'b0;
      led_lt_r  <= 1'b0;
      led_oe_r  <= 1'b1;
      led_a_r   <= '0;
      hpd_r     <= 1'b0;
      r0_r <= '0; g0_r <= '0; b0_r <= '0;
      r1_r <= '0; g1_r <= '0; b1_r <= '0;
    end else begin
      hpd_r     <= 1'b1;
      led_clk_r <= (state_r == ST_SHIFT) && cnt_r[0];
      led_lt_r  <= (state_r == ST_LATCH);
      led_oe_r  <= (state_r != ST_DISPLAY);
      if (state_r == ST_LATCH) begin
        led_a_r <= row_r;
      end
      if ((state_r == ST_SHIFT) && !cnt_r[0]) begin
        r0_r <= r0_s; g0_r <= g0_s; b0_r <= b0_s;
        r1_r <= r1_s; g1_r <= g1_s; b1_r <= b1_s;
      end
    end
  end

  assign dvi_hpd = hpd_r;
  assign led_clk = led_clk_r;
  assign led_lt  = led_lt_r;
  assign led_oe  = led_oe_r;
  assign led_a   = led_a_r;
  assign led_r0  = r0_r;
  assign led_g0  = g0_r;
  assign led_b0  = b0_r;
  assign led_r1  = r1_r;
  assign led_g1  = g1_r;
  assign led_b1  = b1_r;

endmodule

// File: tb/tb_pic_led_scan.sv
// Self-checking bench for pic_led_scan: drives video frames, keeps a
// 256x32 1bpp picture model and compares the scanned-out panel data,
// row order and scan timing against it.
module tb_pic_led_scan;

  logic       clk = 1'b0;
  logic       rst, vs, hs, de;
  logic [7:0] red, green, blue;
  logic       dvi_hpd, led_clk, led_lt, led_oe;
  logic [3:0] led_a;
  logic [3:0] led_r0, led_g0, led_b0, led_r1, led_g1, led_b1;

  int errors = 0;
  int checks = 0;

  // picture model: fb[y][x] = {R,G,B} bit as the panel should show it
  logic [2:0]  fb [0:31][0:255];
  // one captured row pair: {r[3:0], g[3:0], b[3:0]} per column
  logic [11:0] cap_up [0:63];
  logic [11:0] cap_lo [0:63];
  int cap_n, cap_row, cap_period, cap_oe_low;

  pic_led_scan dut (
    .clk(clk), .rst(rst), .vs(vs), .hs(hs), .de(de),
    .red(red), .green(green), .blue(blue),
    .dvi_hpd(dvi_hpd), .led_clk(led_clk), .led_lt(led_lt), .led_oe(led_oe),
    .led_a(led_a),
    .led_r0(led_r0), .led_g0(led_g0), .led_b0(led_b0),
    .led_r1(led_r1), .led_g1(led_g1), .led_b1(led_b1)
  );

  always #5 clk = ~clk;

  // global time limit
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] store_val(logic [7:0] r, logic [7:0] g, logic [7:0] b);
`ifdef RB_SWAP_EN
    return {b[7], g[7], r[7]};
`else
    return {r[7], g[7], b[7]};
`endif
  endfunction

  // expected panel bits for picture row y at panel column c
  function automatic logic [11:0] exp_col(int y, int c);
    logic [11:0] e;
    logic [2:0]  px;
    e = 12'h000;
    for (int p = 0; p < 4; p++) begin
      px       = fb[y][p*64 + c];
      e[8 + p] = px[2];
      e[4 + p] = px[1];
      e[p]     = px[0];
    end
    return e;
  endfunction

  // mode 0: random, 1: solid red, 2: one 0x80 pixel at (70,20), rest bit7 clear
  task automatic send_frame(input int mode, input int nlines, input int npix);
    logic [7:0] r, g, b;
    @(negedge clk); vs = 1'b1; de = 1'b0;
    @(negedge clk); vs = 1'b0;
    @(negedge clk);
    for (int l = 0; l < nlines; l++) begin
      for (int x = 0; x < npix; x++) begin
        case (mode)
          0: begin r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); end
          1: begin r = 8'hFF; g = 8'h00; b = 8'h00; end
          default: begin
            if (x == 70 && l == 20) begin
              r = 8'h80; g = 8'h80; b = 8'h80;
            end else begin
              r = 8'($urandom_range(127, 0));
              g = 8'($urandom_range(127, 0));
              b = 8'($urandom_range(127, 0));
            end
          end
        endcase
        @(negedge clk);
        de = 1'b1; red = r; green = g; blue = b;
        if (x < 256 && l < 32) fb[l][x] = store_val(r, g, b);
      end
      @(negedge clk); de = 1'b0; hs = 1'b1;
      @(negedge clk); hs = 1'b0;
    end
  endtask

  task automatic sync_latch();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (led_lt !== 1'b1 && n < 1000);
    if (led_lt !== 1'b1) begin
      checks++; errors++;
      $display("FAIL sync_latch: no latch pulse in %0d cycles", n);
    end
  endtask

  // record one row's shifted columns up to and including its latch cycle
  task automatic capture_row();
    logic prev;
    prev = led_clk;
    cap_n = 0; cap_period = 0; cap_oe_low = 0;
    do begin
      @(negedge clk);
      cap_period++;
      if (led_oe === 1'b0) cap_oe_low++;
      if (led_clk === 1'b1 && prev === 1'b0) begin
        if (cap_n < 64) begin
          cap_up[cap_n] = {led_r0, led_g0, led_b0};
          cap_lo[cap_n] = {led_r1, led_g1, led_b1};
        end
        cap_n++;
      end
      prev = led_clk;
    end while (led_lt !== 1'b1 && cap_period < 1000);
    cap_row = int'(led_a);
    if (led_lt !== 1'b1) begin
      checks++; errors++;
      $display("FAIL capture_row: no latch in %0d cycles", cap_period);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vs = 1'b0; hs = 1'b0; de = 1'b0;
    red = 8'h00; green = 8'h00; blue = 8'h00;
    repeat (4) @(negedge clk);
    checks++;
    if (led_oe !== 1'b1) begin errors++; $display("FAIL reset_oe: got %b want 1", led_oe); end
    checks++;
    if (led_a !== 4'd0) begin errors++; $display("FAIL reset_a: got %0d want 0", led_a); end
    checks++;
    if (led_lt !== 1'b0 || led_clk !== 1'b0) begin
      errors++; $display("FAIL reset_lt_clk: got lt=%b clk=%b want 0 0", led_lt, led_clk);
    end
    checks++;
    if ({led_r0, led_g0, led_b0, led_r1, led_g1, led_b1} !== 24'h000000) begin
      errors++;
      $display("FAIL reset_colour: got %h want 000000",
               {led_r0, led_g0, led_b0, led_r1, led_g1, led_b1});
    end
    checks++;
    if (dvi_hpd !== 1'b0) begin errors++; $display("FAIL reset_hpd: got %b want 0", dvi_hpd); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dvi_hpd !== 1'b1) begin errors++; $display("FAIL hpd_after_reset: got %b want 1", dvi_hpd); end
  endtask

  // random frame with overlong lines (x>=256) and an extra line (y=32)
  task automatic test_random_frame();
    int bad, first;
    send_frame(0, 33, 260);
    sync_latch();
    for (int k = 0; k < 16; k++) begin
      capture_row();
      bad = 0; first = -1;
      for (int c = 0; c < 64; c++) begin
        if (cap_up[c] !== exp_col(cap_row, c) || cap_lo[c] !== exp_col(cap_row + 16, c)) begin
          bad++;
          if (first < 0) first = c;
        end
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random_row%0d: %0d bad cols, col %0d got up=%h lo=%h want up=%h lo=%h",
                 cap_row, bad, first, cap_up[first], cap_lo[first],
                 exp_col(cap_row, first), exp_col(cap_row + 16, first));
      end
    end
  endtask

  task automatic test_timing();
    int prev_row;
    sync_latch();
    prev_row = int'(led_a);
    for (int k = 0; k < 17; k++) begin
      capture_row();
      checks++;
      if (cap_period != 386) begin errors++; $display("FAIL row_period: got %0d want 386", cap_period); end
      checks++;
      if (cap_n != 64) begin errors++; $display("FAIL shift_clocks: got %0d want 64", cap_n); end
      checks++;
      if (cap_oe_low != 256) begin errors++; $display("FAIL oe_low: got %0d want 256", cap_oe_low); end
      checks++;
      if (cap_row != (prev_row + 1) % 16) begin
        errors++; $display("FAIL row_order: got %0d want %0d", cap_row, (prev_row + 1) % 16);
      end
      prev_row = cap_row;
    end
  endtask

  task automatic test_reset_mid_shift();
    int bad;
    sync_latch();
    repeat (256 + 30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (led_oe !== 1'b1 || led_lt !== 1'b0 || led_clk !== 1'b0 || led_a !== 4'd0 || dvi_hpd !== 1'b0 ||
        {led_r0, led_g0, led_b0, led_r1, led_g1, led_b1} !== 24'h000000) begin
      errors++;
      $display("FAIL midreset_state: got oe=%b lt=%b clk=%b a=%0d hpd=%b col=%h want 1 0 0 0 0 000000",
               led_oe, led_lt, led_clk, led_a, dvi_hpd,
               {led_r0, led_g0, led_b0, led_r1, led_g1, led_b1});
    end
    rst = 1'b0;
    capture_row();
    checks++;
    if (cap_row != 0 || cap_n != 64) begin
      errors++; $display("FAIL midreset_restart: got row=%0d clocks=%0d want 0 64", cap_row, cap_n);
    end
    bad = 0;
    for (int c = 0; c < 64 && c < cap_n; c++) begin
      if (cap_up[c] !== exp_col(0, c) || cap_lo[c] !== exp_col(16, c)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset_image: got %0d bad cols, col0 up=%h lo=%h want 0 bad, up=%h lo=%h",
               bad, cap_up[0], cap_lo[0], exp_col(0, 0), exp_col(16, 0));
    end
  endtask

  task automatic test_solid_red();
    logic [11:0] want;
    int bad_m, bad_c;
`ifdef RB_SWAP_EN
    want = 12'h00F;
`else
    want = 12'hF00;
`endif
    send_frame(1, 32, 256);
    sync_latch();
    for (int k = 0; k < 16; k++) begin
      capture_row();
      bad_m = 0; bad_c = 0;
      for (int c = 0; c < 64; c++) begin
        if (cap_up[c] !== exp_col(cap_row, c) || cap_lo[c] !== exp_col(cap_row + 16, c)) bad_m++;
        if (cap_up[c] !== want || cap_lo[c] !== want) bad_c++;
      end
      checks++;
      if (bad_m != 0) begin
        errors++; $display("FAIL red_model_row%0d: %0d bad cols, want 0", cap_row, bad_m);
      end
      checks++;
      if (bad_c != 0) begin
        errors++;
        $display("FAIL red_const_row%0d: col0 got up=%h lo=%h want %h", cap_row, cap_up[0], cap_lo[0], want);
      end
    end
  endtask

  task automatic test_single_pixel();
    logic [11:0] want_lo;
    int bad_m, bad_c, first;
    send_frame(2, 32, 256);
    sync_latch();
    for (int k = 0; k < 16; k++) begin
      capture_row();
      bad_m = 0; bad_c = 0; first = 0;
      for (int c = 0; c < 64; c++) begin
        want_lo = (cap_row == 4 && c == 6) ? 12'h222 : 12'h000;
        if (cap_up[c] !== exp_col(cap_row, c) || cap_lo[c] !== exp_col(cap_row + 16, c)) bad_m++;
        if (cap_up[c] !== 12'h000 || cap_lo[c] !== want_lo) begin
          if (bad_c == 0) first = c;
          bad_c++;
        end
      end
      checks++;
      if (bad_m != 0) begin
        errors++; $display("FAIL pixel_model_row%0d: %0d bad cols, want 0", cap_row, bad_m);
      end
      checks++;
      if (bad_c != 0) begin
        errors++;
        $display("FAIL pixel_const_row%0d: col %0d got up=%h lo=%h want up=000 lo=%h",
                 cap_row, first, cap_up[first], cap_lo[first],
                 (cap_row == 4 && first == 6) ? 12'h222 : 12'h000);
      end
    end
  endtask

  initial begin
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 256; x++)
        fb[y][x] = 3'b000;
    test_reset();
    test_random_frame();
    test_timing();
    test_reset_mid_shift();
    test_solid_red();
    test_single_pixel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
